// File: rtl/ysyx_22040210_gshare_param_if.sv
// Bundle of the gshare predictor's lookup, restore and training signals.
// The master modport is the core pipeline side; the slave modport is the predictor.
interface ysyx_22040210_gshare_param_if #(
  parameter int PC_W   = 32,
  parameter int HIST_W = 8,
  parameter int CNT_W  = 2
);
  logic              pred_req_i;
  logic [PC_W-1:0]   pred_pc_i;
  logic              btb_hit_i;
  logic              btb_uncond_i;
  logic              pred_taken_o;
  logic [CNT_W-1:0]  pred_cnt_o;
  logic [HIST_W-1:0] pred_hist_o;
  logic              init_busy_o;
  logic              restore_i;
  logic [HIST_W-1:0] restore_hist_i;
  logic              restore_taken_i;
  logic              upd_valid_i;
  logic [PC_W-1:0]   upd_pc_i;
  logic [HIST_W-1:0] upd_hist_i;
  logic              upd_taken_i;

  modport master (
    output pred_req_i, pred_pc_i, btb_hit_i, btb_uncond_i,
    output restore_i, restore_hist_i, restore_taken_i,
    output upd_valid_i, upd_pc_i, upd_hist_i, upd_taken_i,
    input  pred_taken_o, pred_cnt_o, pred_hist_o, init_busy_o
  );

  modport slave (
    input  pred_req_i, pred_pc_i, btb_hit_i, btb_uncond_i,
    input  restore_i, restore_hist_i, restore_taken_i,
    input  upd_valid_i, upd_pc_i, upd_hist_i, upd_taken_i,
    output pred_taken_o, pred_cnt_o, pred_hist_o, init_busy_o
  );
endinterface

// File: rtl/ysyx_22040210_gshare_param.sv
// Parametrised gshare direction predictor: PC^history indexed PHT of saturating
// counters, post-reset init sweep, and a 2-stage read-modify-write training pipe.
module ysyx_22040210_gshare_param #(
  parameter int PC_W     = 32,
  parameter int IDX_W    = 10,
  parameter int HIST_W   = 8,
  parameter int CNT_W    = 2,
  parameter int INIT_CNT = 1,
  parameter int HASH_EN  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic flush,
  ysyx_22040210_gshare_param_if.slave bp
);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam int         DEPTH   = 1 << IDX_W;

  function automatic logic [IDX_W-1:0] idx_of(input logic [PC_W-1:0] pc,
                                               input logic [HIST_W-1:0] h);
    logic [IDX_W-1:0] base;
    base = pc[2 +: IDX_W];
    if (HASH_EN != 0) base = base ^ pc[2+IDX_W +: IDX_W];
    return base ^ IDX_W'(h);
  endfunction

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic t);
    if (t) return (&c) ? c : c + CNT_W'(1);
    return (|c) ? c - CNT_W'(1) : c;
  endfunction

  logic [CNT_W-1:0]  pht_q [0:DEPTH-1];
  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  sweep_idx_q, sweep_idx_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic              u1_valid_q, u1_valid_d, u1_taken_q, u1_taken_d;
  logic [IDX_W-1:0]  u1_idx_q, u1_idx_d;
  logic              u2_valid_q, u2_valid_d;
  logic [IDX_W-1:0]  u2_idx_q, u2_idx_d;
  logic [CNT_W-1:0]  u2_cnt_q, u2_cnt_d;

  logic              run;
  logic [HIST_W-1:0] restore_val, lk_hist;
  logic [CNT_W-1:0]  lk_cnt, u1_cnt;
  logic              pred_taken;
  logic              pht_we;
  logic [IDX_W-1:0]  pht_waddr;
  logic [CNT_W-1:0]  pht_wdata;
  logic              unused_bits;

  assign unused_bits = ^{bp.pred_pc_i, bp.upd_pc_i, bp.restore_hist_i[HIST_W-1]};
  assign run         = (state_q == ST_RUN);
  assign restore_val = {bp.restore_hist_i[HIST_W-2:0], bp.restore_taken_i};

  // Lookup bypasses only the restore load; the speculative shift depends on this
  // very prediction, so it cannot feed back into the same lookup.
  assign lk_hist = bp.restore_i ? restore_val : hist_q;
  assign lk_cnt  = pht_q[idx_of(bp.pred_pc_i, lk_hist)];
  assign pred_taken = run & (lk_cnt[CNT_W-1] | (bp.btb_hit_i & bp.btb_uncond_i));

  assign bp.pred_taken_o = pred_taken;
  assign bp.pred_cnt_o   = run ? lk_cnt : '0;
  assign bp.pred_hist_o  = lk_hist;
  assign bp.init_busy_o  = ~run;

  // U2 result forwarded so back-to-back updates to one entry accumulate.
  assign u1_cnt = (u2_valid_q && (u2_idx_q == u1_idx_q)) ? u2_cnt_q : pht_q[u1_idx_q];

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    hist_d      = hist_q;
    if (!run) begin
      sweep_idx_d = sweep_idx_q + IDX_W'(1);
      if (&sweep_idx_q) state_d = ST_RUN;
    end
    if (bp.restore_i)
      hist_d = restore_val;
    else if (run && bp.pred_req_i && bp.btb_hit_i && !stall && !flush)
      hist_d = {hist_q[HIST_W-2:0], pred_taken};
    u1_valid_d = run & bp.upd_valid_i;
    u1_idx_d   = idx_of(bp.upd_pc_i, bp.upd_hist_i);
    u1_taken_d = bp.upd_taken_i;
    u2_valid_d = u1_valid_q;
    u2_idx_d   = u1_idx_q;
    u2_cnt_d   = sat_step(u1_cnt, u1_taken_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_idx_q <= '0;
      hist_q      <= '0;
      u1_valid_q  <= 1'b0;
      u1_idx_q    <= '0;
      u1_taken_q  <= 1'b0;
      u2_valid_q  <= 1'b0;
      u2_idx_q    <= '0;
      u2_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      hist_q      <= hist_d;
      u1_valid_q  <= u1_valid_d;
      u1_idx_q    <= u1_idx_d;
      u1_taken_q  <= u1_taken_d;
      u2_valid_q  <= u2_valid_d;
      u2_idx_q    <= u2_idx_d;
      u2_cnt_q    <= u2_cnt_d;
    end
  end

  // Single write port: the init sweep owns it until RUN, then the U2 stage.
  assign pht_we    = !rst && (!run || u2_valid_q);
  assign pht_waddr = run ? u2_idx_q : sweep_idx_q;
  assign pht_wdata = run ? u2_cnt_q : CNT_W'(INIT_CNT);

  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
  end
endmodule

// File: tb/tb_ysyx_22040210_gshare_param.sv
// Directed-vector bench for the gshare predictor: init sweep, training, history.
module tb_ysyx_22040210_gshare_param;
  logic clk = 1'b0;
  logic rst, stall, flush;
  int   n_vec = 0;
  int   n_err = 0;

  ysyx_22040210_gshare_param_if #(.PC_W(32), .HIST_W(8), .CNT_W(2)) bp ();

  ysyx_22040210_gshare_param #(
    .PC_W(32), .IDX_W(10), .HIST_W(8), .CNT_W(2), .INIT_CNT(1), .HASH_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bp(bp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        hit, unc, stl, upd;
    logic [31:0] upc;
    logic        ut;
    logic        exp_taken;
    logic [1:0]  exp_cnt;
    logic [7:0]  exp_hist;
  } vec_t;

  vec_t vt[$];

  localparam logic [31:0] P0 = 32'h8000_0000;
  localparam logic [31:0] P1 = 32'h8000_0004;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic add(input logic [31:0] pc, input logic hit, input logic unc, input logic stl,
                     input logic upd, input logic [31:0] upc, input logic ut,
                     input logic et, input logic [1:0] ec);
    vec_t v;
    v.pc = pc; v.hit = hit; v.unc = unc; v.stl = stl; v.upd = upd; v.upc = upc; v.ut = ut;
    v.exp_taken = et; v.exp_cnt = ec; v.exp_hist = 8'h00;
    vt.push_back(v);
  endtask

  // Counts busy cycles from the current cycle onward; lookup inputs hit/uncond
  // and an update request are held during the sweep to prove they are ignored.
  task automatic count_busy(input string tag, output int n);
    n = 0;
    bp.pred_req_i = 1'b1; bp.pred_pc_i = P0;
    bp.btb_hit_i = 1'b1; bp.btb_uncond_i = 1'b1;
    bp.upd_valid_i = 1'b1; bp.upd_pc_i = P0; bp.upd_hist_i = 8'h00; bp.upd_taken_i = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!bp.init_busy_o) break;
      if (k == 0) begin
        check({tag, "_init_taken"}, 32'(bp.pred_taken_o), 32'd0);
        check({tag, "_init_cnt"}, 32'(bp.pred_cnt_o), 32'd0);
        check({tag, "_init_hist"}, 32'(bp.pred_hist_o), 32'd0);
      end
      n++;
      tick();
      if (k == 1000) begin
        bp.upd_valid_i = 1'b0;
        bp.btb_hit_i = 1'b0;
        bp.btb_uncond_i = 1'b0;
      end
    end
    $display("%s: init_busy_o high for %0d cycles", tag, n);
  endtask

  initial begin
    int nb;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    bp.pred_req_i = 1'b0; bp.pred_pc_i = '0; bp.btb_hit_i = 1'b0; bp.btb_uncond_i = 1'b0;
    bp.restore_i = 1'b0; bp.restore_hist_i = '0; bp.restore_taken_i = 1'b0;
    bp.upd_valid_i = 1'b0; bp.upd_pc_i = '0; bp.upd_hist_i = '0; bp.upd_taken_i = 1'b0;

    // Training table, one vector per cycle; updates become visible 3 cycles later.
    add(P0,0,0,0, 1,P0,1, 0,2'd1);  // c0
    add(P0,0,0,0, 0,P0,0, 0,2'd1);
    add(P0,0,0,0, 1,P0,1, 0,2'd1);  // c2: same-cycle write, old value seen
    add(P0,0,0,0, 0,P0,0, 1,2'd2);
    add(P0,0,0,0, 1,P0,1, 1,2'd2);  // c4
    add(P0,0,0,0, 0,P0,0, 1,2'd3);
    add(P0,0,0,0, 1,P0,0, 1,2'd3);  // c6: saturated, first not-taken
    add(P0,0,0,0, 0,P0,0, 1,2'd3);
    add(P0,0,0,0, 1,P0,0, 1,2'd3);  // c8
    add(P0,0,0,0, 0,P0,0, 1,2'd2);
    add(P0,0,0,0, 1,P0,0, 1,2'd2);  // c10
    add(P0,0,0,0, 0,P0,0, 0,2'd1);
    add(P0,0,0,0, 1,P0,0, 0,2'd1);  // c12
    add(P0,0,0,0, 0,P0,0, 0,2'd0);
    add(P0,0,0,0, 1,P0,0, 0,2'd0);  // c14: floor
    add(P0,0,0,0, 0,P0,0, 0,2'd0);
    add(P0,0,0,0, 0,P0,0, 0,2'd0);
    add(P0,0,0,0, 0,P0,0, 0,2'd0);
    add(P1,0,0,0, 1,P1,1, 0,2'd1);  // c18: back-to-back on idx 1
    add(P1,0,0,0, 1,P1,1, 0,2'd1);
    add(P1,0,0,0, 0,P1,0, 0,2'd1);
    add(P1,0,0,0, 0,P1,0, 1,2'd2);
    add(P1,0,0,0, 0,P1,0, 1,2'd3);  // c22: forwarded second increment
    add(32'h8000_1004,0,0,0, 0,P0,0, 0,2'd0);  // folded hash -> idx 0
    add(32'h8000_1000,0,0,0, 0,P0,0, 1,2'd3);  // folded hash -> idx 1
    add(P0,1,1,1, 0,P0,0, 1,2'd0);  // unconditional overrides weak counter
    add(P0,1,0,1, 0,P0,0, 0,2'd0);

    tick();
    tick();
    pulse_reset();
    count_busy("rst1", nb);
    check("rst1_busy_cycles", 32'(nb), 32'd1024);
    check("rst1_cnt_after", 32'(bp.pred_cnt_o), 32'd1);
    check("rst1_taken_after", 32'(bp.pred_taken_o), 32'd0);
    check("rst1_hist_after", 32'(bp.pred_hist_o), 32'd0);
    tick();

    foreach (vt[i]) begin
      bp.pred_req_i = 1'b1; bp.pred_pc_i = vt[i].pc;
      bp.btb_hit_i = vt[i].hit; bp.btb_uncond_i = vt[i].unc; stall = vt[i].stl;
      bp.upd_valid_i = vt[i].upd; bp.upd_pc_i = vt[i].upc;
      bp.upd_hist_i = 8'h00; bp.upd_taken_i = vt[i].ut;
      @(negedge clk);
      $display("vec %0d: pc=%h taken=%0d cnt=%0d hist=%h", i, vt[i].pc,
               bp.pred_taken_o, bp.pred_cnt_o, bp.pred_hist_o);
      check($sformatf("vec%0d_taken", i), 32'(bp.pred_taken_o), 32'(vt[i].exp_taken));
      check($sformatf("vec%0d_cnt", i), 32'(bp.pred_cnt_o), 32'(vt[i].exp_cnt));
      check($sformatf("vec%0d_hist", i), 32'(bp.pred_hist_o), 32'(vt[i].exp_hist));
      tick();
    end
    bp.upd_valid_i = 1'b0;

    // Speculative history: two taken lookups shift in 1s, then stall/flush hold.
    bp.pred_pc_i = P0; bp.btb_hit_i = 1'b1; bp.btb_uncond_i = 1'b1; stall = 1'b0;
    @(negedge clk); check("hist_shift0", 32'(bp.pred_hist_o), 32'h00);
    tick();
    @(negedge clk); check("hist_shift1", 32'(bp.pred_hist_o), 32'h01);
    tick();
    stall = 1'b1;
    @(negedge clk); check("hist_shift2", 32'(bp.pred_hist_o), 32'h03);
    tick();
    stall = 1'b0; flush = 1'b1;
    @(negedge clk); check("hist_stall_hold", 32'(bp.pred_hist_o), 32'h03);
    tick();
    flush = 1'b0; stall = 1'b1;
    @(negedge clk); check("hist_flush_hold", 32'(bp.pred_hist_o), 32'h03);

    // Restore overrides stall and is bypassed into the same-cycle lookup.
    bp.restore_i = 1'b1; bp.restore_hist_i = 8'hA5; bp.restore_taken_i = 1'b0;
    #1;
    check("restore_bypass_hist", 32'(bp.pred_hist_o), 32'h4A);
    check("restore_bypass_cnt", 32'(bp.pred_cnt_o), 32'd1);
    tick();
    bp.restore_i = 1'b0; bp.btb_hit_i = 1'b0; bp.btb_uncond_i = 1'b0;
    @(negedge clk);
    check("restore_hist_next", 32'(bp.pred_hist_o), 32'h4A);
    check("restore_taken_next", 32'(bp.pred_taken_o), 32'd0);
    tick();
    stall = 1'b0;

    // Reset in the middle of the sweep restarts it from index 0.
    pulse_reset();
    repeat (500) tick();
    @(negedge clk); check("mid_sweep_busy", 32'(bp.init_busy_o), 32'd1);
    tick();
    pulse_reset();
    count_busy("rst2", nb);
    check("rst2_busy_cycles", 32'(nb), 32'd1024);
    check("rst2_cnt_idx0", 32'(bp.pred_cnt_o), 32'd1);
    bp.pred_pc_i = P1;
    #1;
    check("rst2_cnt_idx1", 32'(bp.pred_cnt_o), 32'd1);
    check("rst2_hist", 32'(bp.pred_hist_o), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
